// File: rtl/mem_unified_sized_if.sv
// Request/response bus of the unified instruction/data memory.
// The master drives requests; the slave (the memory) accepts them and returns one response pulse.
interface mem_unified_sized_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/mem_unified_sized.sv
// Byte-addressable little-endian memory with byte/half/word access, wait states and fault reporting.
// Optional sticky fault log (fault_sticky/fault_addr) is enabled by defining MEM_FAULT_LOG_EN.
module mem_unified_sized #(
  parameter int    ADDR_WIDTH  = 8,
  parameter int    WAIT_CYCLES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic               clk,
  input  logic               reset,
  mem_unified_sized_if.slave bus
`ifdef MEM_FAULT_LOG_EN
  ,
  output logic               fault_sticky,
  output logic [31:0]        fault_addr
`endif
);

  localparam int          ROW_W     = ADDR_WIDTH - 2;
  localparam int          DEPTH     = 1 << ROW_W;
  localparam logic [32:0] MEM_BYTES = 33'd1 << ADDR_WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg;
  logic        write_reg;
  logic [1:0]  size_reg;
  logic        unsigned_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;

  logic [1:0]  rsp_off_reg;
  logic [1:0]  rsp_size_reg;
  logic        rsp_unsigned_reg;
  logic        rsp_zero_reg;
  logic        rsp_error_reg;

  logic        accept;
  logic        enter_resp;
  logic        mem_we;
  logic        mem_re;

  logic        eff_write;
  logic [1:0]  eff_size;
  logic        eff_unsigned;
  logic [31:0] eff_addr;
  logic [31:0] eff_wdata;
  logic [1:0]  eff_off;
  logic [ROW_W-1:0] eff_row;
  logic [2:0]  eff_nbytes;
  logic        eff_fault;

  logic [31:0] lane_rdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] rdata_ext;

  assign accept     = (state_reg == ST_IDLE) && bus.req_valid;
  assign enter_resp = (state_next == ST_RESP);

  // With zero wait states RESP is entered on the accept edge itself, so the
  // request has to be taken straight from the bus rather than from the latches.
  always_comb begin
    if (state_reg == ST_IDLE) begin
      eff_write    = bus.req_write;
      eff_size     = bus.req_size;
      eff_unsigned = bus.req_unsigned;
      eff_addr     = bus.req_addr;
      eff_wdata    = bus.req_wdata;
    end else begin
      eff_write    = write_reg;
      eff_size     = size_reg;
      eff_unsigned = unsigned_reg;
      eff_addr     = addr_reg;
      eff_wdata    = wdata_reg;
    end
  end

  assign eff_off = eff_addr[1:0];
  assign eff_row = eff_addr[ADDR_WIDTH-1:2];

  always_comb begin
    eff_nbytes = 3'd0;
    case (eff_size)
      2'd0:    eff_nbytes = 3'd1;
      2'd1:    eff_nbytes = 3'd2;
      2'd2:    eff_nbytes = 3'd4;
      default: eff_nbytes = 3'd0;
    endcase
  end

  always_comb begin
    eff_fault = 1'b0;
    if (eff_size == 2'd3)
      eff_fault = 1'b1;
    if (eff_size == 2'd1 && eff_addr[0])
      eff_fault = 1'b1;
    if (eff_size == 2'd2 && eff_off != 2'd0)
      eff_fault = 1'b1;
    if ({1'b0, eff_addr} >= MEM_BYTES)
      eff_fault = 1'b1;
  end

  // Gating with reset keeps an aborted store from landing in storage.
  assign mem_we = enter_resp && eff_write && !eff_fault && reset;
  assign mem_re = enter_resp;

  // Storage is split into four byte lanes so an aligned access touches each lane at most once.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] rdata_reg;
      logic [1:0] idx;
      logic       lane_we;
      logic [7:0] lane_wdata;

      assign idx        = 2'(gi) - eff_off;
      assign lane_we    = mem_we && ({1'b0, idx} < eff_nbytes);
      assign lane_wdata = eff_wdata[8*idx +: 8];

      always_ff @(posedge clk) begin
        if (lane_we)
          lane_mem[eff_row] <= lane_wdata;
        if (mem_re)
          rdata_reg <= lane_mem[eff_row];
      end

      assign lane_rdata[8*gi +: 8] = rdata_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept)
          state_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: begin
        if (cnt_reg <= 4'd1)
          state_next = ST_RESP;
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_reg == ST_IDLE);
    bus.resp_valid = (state_reg == ST_RESP);
    bus.resp_rdata = rdata_ext;
    bus.resp_error = rsp_error_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg      <= 4'd0;
      write_reg    <= 1'b0;
      size_reg     <= 2'd0;
      unsigned_reg <= 1'b0;
      addr_reg     <= 32'd0;
      wdata_reg    <= 32'd0;
    end else if (accept) begin
      cnt_reg      <= 4'(WAIT_CYCLES);
      write_reg    <= bus.req_write;
      size_reg     <= bus.req_size;
      unsigned_reg <= bus.req_unsigned;
      addr_reg     <= bus.req_addr;
      wdata_reg    <= bus.req_wdata;
    end else if (state_reg == ST_WAIT) begin
      cnt_reg <= cnt_reg - 4'd1;
    end
  end

  // Response descriptor is captured alongside the lane read so the result holds until the next response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_off_reg      <= 2'd0;
      rsp_size_reg     <= 2'd0;
      rsp_unsigned_reg <= 1'b0;
      rsp_zero_reg     <= 1'b1;
      rsp_error_reg    <= 1'b0;
    end else if (enter_resp) begin
      rsp_off_reg      <= eff_off;
      rsp_size_reg     <= eff_size;
      rsp_unsigned_reg <= eff_unsigned;
      rsp_zero_reg     <= eff_write || eff_fault;
      rsp_error_reg    <= eff_fault;
    end
  end

  assign byte_sel = lane_rdata[8*rsp_off_reg +: 8];
  assign half_sel = lane_rdata[16*rsp_off_reg[1] +: 16];

  always_comb begin
    rdata_ext = 32'd0;
    case (rsp_size_reg)
      2'd0:    rdata_ext = {{24{!rsp_unsigned_reg && byte_sel[7]}}, byte_sel};
      2'd1:    rdata_ext = {{16{!rsp_unsigned_reg && half_sel[15]}}, half_sel};
      default: rdata_ext = lane_rdata;
    endcase
    if (rsp_zero_reg)
      rdata_ext = 32'd0;
  end

`ifdef MEM_FAULT_LOG_EN
  logic        fault_sticky_reg;
  logic [31:0] fault_addr_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_sticky_reg <= 1'b0;
      fault_addr_reg   <= 32'd0;
    end else if (enter_resp && eff_fault && !fault_sticky_reg) begin
      fault_sticky_reg <= 1'b1;
      fault_addr_reg   <= eff_addr;
    end
  end

  assign fault_sticky = fault_sticky_reg;
  assign fault_addr   = fault_addr_reg;
`endif

endmodule

// File: tb/tb_mem_unified_sized.sv
// Directed test of mem_unified_sized with one and zero wait states.
module tb_mem_unified_sized;

  logic clk = 1'b0;
  logic reset;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  mem_unified_sized_if bus1 ();
  mem_unified_sized_if bus0 ();

`ifdef MEM_FAULT_LOG_EN
  logic        fs1, fs0;
  logic [31:0] fa1, fa0;
`endif

  mem_unified_sized #(.ADDR_WIDTH(8), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(reset), .bus(bus1)
`ifdef MEM_FAULT_LOG_EN
    , .fault_sticky(fs1), .fault_addr(fa1)
`endif
  );

  mem_unified_sized #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .bus(bus0)
`ifdef MEM_FAULT_LOG_EN
    , .fault_sticky(fs0), .fault_addr(fa0)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request on the WAIT_CYCLES=1 instance; request fields are scrambled after accept.
  task automatic do_txn(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    bus1.req_valid    = 1'b1;
    bus1.req_write    = w;
    bus1.req_size     = sz;
    bus1.req_unsigned = u;
    bus1.req_addr     = a;
    bus1.req_wdata    = wd;
    @(posedge clk);
    #1;
    bus1.req_valid = 1'b0;
    bus1.req_write = ~w;
    bus1.req_size  = 2'd3;
    bus1.req_addr  = 32'hFFFF_FFFF;
    bus1.req_wdata = 32'h5A5A_5A5A;
    lat = 0;
    rd  = 32'hXXXX_XXXX;
    er  = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus1.resp_valid) begin
        lat = n;
        rd  = bus1.resp_rdata;
        er  = bus1.resp_error;
        break;
      end
    end
    $display("txn w=%0d size=%0d uns=%0d addr=%h wdata=%h -> rdata=%h err=%b lat=%0d",
             w, sz, u, a, wd, rd, er, lat);
  endtask

  task automatic txn_check(input string tag, input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_txn(w, sz, u, a, wd, rd, er, lat);
    check_vec({tag, "_lat"}, 32'(lat), 32'd2);
    check_vec({tag, "_rdata"}, rd, exp_rd);
    check_vec({tag, "_err"}, {31'd0, er}, {31'd0, exp_er});
  endtask

  initial begin
    logic [3:0]  rdy_seq, vld_seq;
    logic        pulse;

    reset = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_size = 2'd0;
    bus1.req_unsigned = 1'b0; bus1.req_addr = 32'd0; bus1.req_wdata = 32'd0;
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_size = 2'd0;
    bus0.req_unsigned = 1'b0; bus0.req_addr = 32'd0; bus0.req_wdata = 32'd0;

    repeat (3) @(negedge clk);
    check_vec("rst_ready", {31'd0, bus1.req_ready}, 32'd1);
    check_vec("rst_valid", {31'd0, bus1.resp_valid}, 32'd0);
    check_vec("rst_rdata", bus1.resp_rdata, 32'd0);
    check_vec("rst_error", {31'd0, bus1.resp_error}, 32'd0);
    check_vec("rst_ready0", {31'd0, bus0.req_ready}, 32'd1);
    reset = 1'b1;

    // word store/load and byte extension
    txn_check("sw80",  1'b1, 2'd2, 1'b0, 32'h80, 32'hDEADBEEF, 32'h0, 1'b0);
    txn_check("lw80",  1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 32'hDEADBEEF, 1'b0);
    txn_check("lb83",  1'b0, 2'd0, 1'b0, 32'h83, 32'h0, 32'hFFFFFFDE, 1'b0);
    txn_check("lbu83", 1'b0, 2'd0, 1'b1, 32'h83, 32'h0, 32'h000000DE, 1'b0);

    // half store merges into an existing word
    txn_check("sw90",  1'b1, 2'd2, 1'b0, 32'h90, 32'h11223344, 32'h0, 1'b0);
    txn_check("sh92",  1'b1, 2'd1, 1'b0, 32'h92, 32'hFFFF8001, 32'h0, 1'b0);
    txn_check("lw90",  1'b0, 2'd2, 1'b0, 32'h90, 32'h0, 32'h80013344, 1'b0);
    txn_check("lh92",  1'b0, 2'd1, 1'b0, 32'h92, 32'h0, 32'hFFFF8001, 1'b0);
    txn_check("lhu92", 1'b0, 2'd1, 1'b1, 32'h92, 32'h0, 32'h00008001, 1'b0);
    txn_check("lb90",  1'b0, 2'd0, 1'b0, 32'h90, 32'h0, 32'h00000044, 1'b0);
    txn_check("sb91",  1'b1, 2'd0, 1'b0, 32'h91, 32'h000000A5, 32'h0, 1'b0);
    txn_check("lw90b", 1'b0, 2'd2, 1'b0, 32'h90, 32'h0, 32'h8001A544, 1'b0);

    // faults leave storage alone and return zero data
    txn_check("sw84",  1'b1, 2'd2, 1'b0, 32'h84, 32'h55667788, 32'h0, 1'b0);
    txn_check("lw80c", 1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 32'hDEADBEEF, 1'b0);
    txn_check("f_lw81",  1'b0, 2'd2, 1'b0, 32'h81, 32'h0, 32'h0, 1'b1);
    txn_check("f_lh85",  1'b0, 2'd1, 1'b0, 32'h85, 32'h0, 32'h0, 1'b1);
    txn_check("f_sz3",   1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1);
    txn_check("f_lw100", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
    txn_check("f_sw82",  1'b1, 2'd2, 1'b0, 32'h82, 32'hFFFFFFFF, 32'h0, 1'b1);
    txn_check("f_sh87",  1'b1, 2'd1, 1'b0, 32'h87, 32'hFFFFFFFF, 32'h0, 1'b1);
    txn_check("lw80d", 1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 32'hDEADBEEF, 1'b0);
    txn_check("lw84d", 1'b0, 2'd2, 1'b0, 32'h84, 32'h0, 32'h55667788, 1'b0);

    // zero wait states, req_valid held high: accepts two cycles apart
    @(negedge clk);
    bus0.req_valid = 1'b1; bus0.req_write = 1'b1; bus0.req_size = 2'd2;
    bus0.req_unsigned = 1'b0; bus0.req_addr = 32'h10; bus0.req_wdata = 32'h0BADF00D;
    for (int k = 0; k < 4; k++) begin
      rdy_seq[k] = bus0.req_ready;
      vld_seq[k] = bus0.resp_valid;
      @(negedge clk);
    end
    bus0.req_valid = 1'b0;
    $display("txn w0 b2b store addr=00000010 ready_seq=%b valid_seq=%b", rdy_seq, vld_seq);
    check_vec("w0_ready_seq", {28'd0, rdy_seq}, 32'h5);
    check_vec("w0_valid_seq", {28'd0, vld_seq}, 32'hA);
    @(negedge clk);
    bus0.req_valid = 1'b1; bus0.req_write = 1'b0; bus0.req_addr = 32'h10;
    @(posedge clk);
    #1 bus0.req_valid = 1'b0;
    @(negedge clk);
    $display("txn w0 load addr=00000010 -> rdata=%h valid=%b", bus0.resp_rdata, bus0.resp_valid);
    check_vec("w0_lw_valid", {31'd0, bus0.resp_valid}, 32'd1);
    check_vec("w0_lw_rdata", bus0.resp_rdata, 32'h0BADF00D);

    // reset during WAIT aborts a store
    txn_check("swA0", 1'b1, 2'd2, 1'b0, 32'hA0, 32'h12345678, 32'h0, 1'b0);
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_write = 1'b1; bus1.req_size = 2'd2;
    bus1.req_addr = 32'hA0; bus1.req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 bus1.req_valid = 1'b0;
    @(negedge clk);
    check_vec("abort_in_wait", {31'd0, bus1.req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check_vec("abort_ready", {31'd0, bus1.req_ready}, 32'd1);
    pulse = bus1.resp_valid;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) reset = 1'b1;
      pulse = pulse | bus1.resp_valid;
    end
    $display("txn abort store addr=000000a0 resp_pulse=%b", pulse);
    check_vec("abort_no_pulse", {31'd0, pulse}, 32'd0);
    txn_check("lwA0", 1'b0, 2'd2, 1'b0, 32'hA0, 32'h0, 32'h12345678, 1'b0);

`ifdef MEM_FAULT_LOG_EN
    txn_check("fl_lw41", 1'b0, 2'd2, 1'b0, 32'h41, 32'h0, 32'h0, 1'b1);
    txn_check("fl_lh43", 1'b0, 2'd1, 1'b0, 32'h43, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    check_vec("fl_sticky", {31'd0, fs1}, 32'd1);
    check_vec("fl_addr", fa1, 32'h41);
    check_vec("fl_sticky0", {31'd0, fs0}, 32'd0);
    reset = 1'b0;
    #1;
    check_vec("fl_rst_sticky", {31'd0, fs1}, 32'd0);
    check_vec("fl_rst_addr", fa1, 32'h0);
    @(negedge clk);
    reset = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
